// File: rtl/i_cache_sa_pkg.sv
// i_cache_sa_pkg: state encoding and width helpers shared by the I-cache files.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package i_cache_sa_pkg;

   // Refill FSM: IDLE serves lookups, REFILL runs the word-serial burst.
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } ic_state_t;

   // Bit width needed to index n items, never less than one bit so that
   // degenerate configurations (1 way, 1 word per line) still get a signal.
   function automatic int unsigned width_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i_cache_sa_if.sv
// i_cache_sa_if: fetch-side and refill-side signals of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: refill side stalls on i_MemReady; fetch side is told to wait by o_Stall.
//
// Signals:
//   i_Addr      fetch address (PC), bits [1:0] ignored
//   i_flush     one-cycle invalidate-all pulse (FENCE.I)
//   o_Data      fetched instruction, valid when o_Stall = 0
//   o_Stall     lookup missed or refill in progress
//   i_DataBlock refill word returned by memory
//   i_MemReady  refill word valid / request accepted
//   o_DataReq   refill word request
//   o_MemAddr   word-aligned address of the requested refill word
interface i_cache_sa_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] i_Addr;
   logic            i_flush;
   logic [XLEN-1:0] o_Data;
   logic            o_Stall;
   logic [XLEN-1:0] i_DataBlock;
   logic            i_MemReady;
   logic            o_DataReq;
   logic [XLEN-1:0] o_MemAddr;

   // Cache side.
   modport slave (
      input  i_Addr, i_flush, i_DataBlock, i_MemReady,
      output o_Data, o_Stall, o_DataReq, o_MemAddr
   );

   // Core + memory side.
   modport master (
      output i_Addr, i_flush, i_DataBlock, i_MemReady,
      input  o_Data, o_Stall, o_DataReq, o_MemAddr
   );
endinterface

// File: rtl/i_cache_sa_way.sv
// ic_way: tag/valid/data storage of one cache way; async read, sync write.
// Latency: reads combinational, writes take effect at the next rising edge.
// Backpressure: none; the caller sequences writes.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (valid bits only)
//   rd_idx, rd_off        lookup set and word offset
//   rd_vld, rd_tag, rd_data  lookup result for this way
//   wr_idx, wr_beat, wr_data, data_we  refill word write
//   tag_we, wr_tag        tag write for wr_idx
//   valid_set             mark wr_idx valid
//   clr_all               invalidate every set (wins over valid_set)
module ic_way
   import i_cache_sa_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int SETS        = 16,
   parameter int BLOCK_WORDS = 4,
   parameter int TAGW        = 24,
   localparam int IDXW       = $clog2(SETS),
   localparam int OFFW       = width_min1(BLOCK_WORDS)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [IDXW-1:0] rd_idx,
   input  logic [OFFW-1:0] rd_off,
   output logic            rd_vld,
   output logic [TAGW-1:0] rd_tag,
   output logic [XLEN-1:0] rd_data,
   input  logic [IDXW-1:0] wr_idx,
   input  logic [OFFW-1:0] wr_beat,
   input  logic [XLEN-1:0] wr_data,
   input  logic            data_we,
   input  logic            tag_we,
   input  logic [TAGW-1:0] wr_tag,
   input  logic            valid_set,
   input  logic            clr_all
);

   logic [SETS-1:0] valid_q;
   logic [TAGW-1:0] tag_q  [SETS];
   logic [XLEN-1:0] data_q [SETS][BLOCK_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= '0;
      end else if (clr_all) begin
         valid_q <= '0;
      end else if (valid_set) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Payload arrays are deliberately left unreset; valid bits gate their use.
   always_ff @(posedge i_clk) begin
      if (data_we) begin
         data_q[wr_idx][wr_beat] <= wr_data;
      end
      if (tag_we) begin
         tag_q[wr_idx] <= wr_tag;
      end
   end

   assign rd_vld  = valid_q[rd_idx];
   assign rd_tag  = tag_q[rd_idx];
   assign rd_data = data_q[rd_idx][rd_off];

endmodule

// File: rtl/i_cache_sa.sv
// i_cache_sa: N-way set-associative instruction cache with word-serial block refill.
// Latency: hits return o_Data combinationally in the lookup cycle; a miss stalls for the burst.
// Backpressure: refill beats advance only on i_MemReady; the core is held with o_Stall.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus           i_cache_sa_if.slave: i_Addr/i_flush/o_Data/o_Stall toward the core,
//                 o_DataReq/o_MemAddr/i_DataBlock/i_MemReady toward instruction memory
module i_cache_sa
   import i_cache_sa_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int WAYS        = 2,
   parameter int SETS        = 16,
   parameter int BLOCK_WORDS = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   i_cache_sa_if.slave bus
);

   localparam int OFF  = 2 + $clog2(BLOCK_WORDS);
   localparam int IDX  = $clog2(SETS);
   localparam int TAGW = XLEN - OFF - IDX;
   localparam int OFFW = width_min1(BLOCK_WORDS);
   localparam int WAYW = width_min1(WAYS);

   // ---------------- lookup address split ----------------
   logic [IDX-1:0]  lk_idx;
   logic [TAGW-1:0] lk_tag;
   logic [OFFW-1:0] lk_off;
   logic [1:0]      unused_addr_lsb;

   assign lk_idx          = bus.i_Addr[OFF+IDX-1:OFF];
   assign lk_tag          = bus.i_Addr[XLEN-1:OFF+IDX];
   assign unused_addr_lsb = bus.i_Addr[1:0];

   generate
      if (BLOCK_WORDS > 1) begin : g_off
         assign lk_off = bus.i_Addr[OFF-1:2];
      end else begin : g_off_single
         assign lk_off = '0;
      end
   endgenerate

   // ---------------- FSM / refill state ----------------
   ic_state_t       state_q, state_n;
   logic [OFFW-1:0] beat_q, beat_n;
   logic [XLEN-1:0] base_q, base_n;
   logic [WAYW-1:0] victim_q, victim_n;
   logic            flush_pend_q, flush_pend_n;
   logic [WAYW-1:0] rr_q [SETS];

   // The refill writes the set/tag of the latched base, not the live PC.
   logic [IDX-1:0]  fill_idx;
   logic [TAGW-1:0] fill_tag;
   assign fill_idx = base_q[OFF+IDX-1:OFF];
   assign fill_tag = base_q[XLEN-1:OFF+IDX];

   // ---------------- way storage ----------------
   logic            way_vld  [WAYS];
   logic [TAGW-1:0] way_tag  [WAYS];
   logic [XLEN-1:0] way_data [WAYS];

   logic data_we, tag_we, valid_set, clr_all, rr_adv;

   generate
      for (genvar w = 0; w < WAYS; w++) begin : g_way
         logic sel;
         assign sel = (victim_q == WAYW'(w));

         ic_way #(
            .XLEN        (XLEN),
            .SETS        (SETS),
            .BLOCK_WORDS (BLOCK_WORDS),
            .TAGW        (TAGW)
         ) u_way (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .rd_idx    (lk_idx),
            .rd_off    (lk_off),
            .rd_vld    (way_vld[w]),
            .rd_tag    (way_tag[w]),
            .rd_data   (way_data[w]),
            .wr_idx    (fill_idx),
            .wr_beat   (beat_q),
            .wr_data   (bus.i_DataBlock),
            .data_we   (data_we && sel),
            .tag_we    (tag_we && sel),
            .wr_tag    (fill_tag),
            .valid_set (valid_set && sel),
            .clr_all   (clr_all)
         );
      end
   endgenerate

   // ---------------- hit detection ----------------
   // At most one way can match, so the data mux is a plain OR of gated words.
   logic            hit;
   logic [XLEN-1:0] hit_data;

   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_vld[w] && (way_tag[w] == lk_tag)) begin
            hit      = 1'b1;
            hit_data = hit_data | way_data[w];
         end
      end
   end

   // ---------------- victim selection ----------------
   // Fill empty ways lowest-first; only a full set falls back to round-robin.
   logic [WAYW-1:0] victim_sel;
   logic            found_free;

   always_comb begin
      victim_sel = rr_q[lk_idx];
      found_free = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found_free && !way_vld[w]) begin
            victim_sel = WAYW'(w);
            found_free = 1'b1;
         end
      end
   end

   // ---------------- FSM next state / outputs ----------------
   logic            last_beat;
   logic            flush_eff;
   logic [XLEN-1:0] data_o, mem_addr_o;
   logic            stall_o, req_o;

   assign last_beat = (beat_q == OFFW'(BLOCK_WORDS - 1));
   // A flush arriving on the final beat counts as pending for that completion.
   assign flush_eff = flush_pend_q | bus.i_flush;

   always_comb begin
      state_n      = state_q;
      beat_n       = beat_q;
      base_n       = base_q;
      victim_n     = victim_q;
      flush_pend_n = flush_pend_q;
      data_we      = 1'b0;
      tag_we       = 1'b0;
      valid_set    = 1'b0;
      clr_all      = 1'b0;
      rr_adv       = 1'b0;
      stall_o      = 1'b1;
      data_o       = '0;
      req_o        = 1'b0;
      mem_addr_o   = '0;

      case (state_q)
         ST_IDLE: begin
            // Lookup below still sees the pre-flush valid bits.
            clr_all = bus.i_flush;
            if (hit) begin
               stall_o = 1'b0;
               data_o  = hit_data;
            end else begin
               state_n  = ST_REFILL;
               beat_n   = '0;
               base_n   = {bus.i_Addr[XLEN-1:OFF], {OFF{1'b0}}};
               victim_n = victim_sel;
            end
         end

         ST_REFILL: begin
            req_o      = 1'b1;
            mem_addr_o = base_q + (XLEN'(beat_q) << 2);
            if (bus.i_flush) begin
               flush_pend_n = 1'b1;
            end
            if (bus.i_MemReady) begin
               data_we = 1'b1;
               beat_n  = beat_q + 1'b1;
               if (last_beat) begin
                  tag_we       = 1'b1;
                  valid_set    = !flush_eff;
                  clr_all      = flush_eff;
                  flush_pend_n = 1'b0;
                  rr_adv       = 1'b1;
                  beat_n       = '0;
                  state_n      = ST_IDLE;
               end
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign bus.o_Data    = data_o;
   assign bus.o_Stall   = stall_o;
   assign bus.o_DataReq = req_o;
   assign bus.o_MemAddr = mem_addr_o;

   // ---------------- state registers ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         beat_q       <= '0;
         base_q       <= '0;
         victim_q     <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_n;
         beat_q       <= beat_n;
         base_q       <= base_n;
         victim_q     <= victim_n;
         flush_pend_q <= flush_pend_n;
      end
   end

   // Round-robin pointer moves only when a refill lands in its set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
         end
      end else if (rr_adv) begin
         if (rr_q[fill_idx] == WAYW'(WAYS - 1)) begin
            rr_q[fill_idx] <= '0;
         end else begin
            rr_q[fill_idx] <= rr_q[fill_idx] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i_cache_sa.sv
// tb_i_cache_sa: directed and random fetch sequences against a set/way/line reference model.
// Latency: n/a (testbench).
// Backpressure: memory responder asserts i_MemReady with a configurable period.
module tb_i_cache_sa;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   i_cache_sa_if #(.XLEN(32)) bus ();

   i_cache_sa #(
      .XLEN        (32),
      .WAYS        (2),
      .SETS        (4),
      .BLOCK_WORDS (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: 4 sets x 2 ways x 4 words, round-robin pointer per set.
   bit          m_valid [4][2];
   logic [25:0] m_tag   [4][2];
   logic [31:0] m_data  [4][2][4];
   int          m_rr    [4];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + (a - 32'h100) / 4;
      return 32'h5EED_0000 ^ a ^ {a[18:0], 13'b0};
   endfunction

   task automatic model_clear_valid();
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 2; w++)
            m_valid[s][w] = 1'b0;
   endtask

   task automatic model_reset();
      model_clear_valid();
      for (int s = 0; s < 4; s++) m_rr[s] = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      model_reset();
   endtask

   // One lookup, plus the refill burst if it misses. Starts at posedge+2 of
   // the lookup cycle and returns at posedge+2 (or +3 after an abort) of the
   // next cycle the core may use.
   task automatic fetch(input logic [31:0] addr, input int period, input int flush_beat,
                        input bit flush_now, input int rst_beat,
                        output bit hit_o, output int stall_cyc);
      int          set, off, way, vic, beat, cyc;
      logic [25:0] tag;
      logic [31:0] base, word;
      bit          hit, pend, aborted, rdy, fl, rs;

      set = int'((addr >> 4) & 32'h3);
      off = int'((addr >> 2) & 32'h3);
      tag = addr[31:6];
      hit = 1'b0;
      way = 0;
      for (int w = 0; w < 2; w++)
         if (m_valid[set][w] && m_tag[set][w] == tag) begin hit = 1'b1; way = w; end
      vic = m_rr[set];
      for (int w = 1; w >= 0; w--)
         if (!m_valid[set][w]) vic = w;

      bus.i_Addr     = addr;
      bus.i_flush    = flush_now;
      bus.i_MemReady = 1'b0;
      #1;
      hit_o     = !bus.o_Stall;
      stall_cyc = bus.o_Stall ? 1 : 0;
      chk("lookup_stall", 32'(bus.o_Stall), hit ? 32'd0 : 32'd1);
      chk("lookup_req",   32'(bus.o_DataReq), 32'd0);
      chk("lookup_data",  bus.o_Data, hit ? m_data[set][way][off] : 32'd0);
      @(posedge clk); #2;
      bus.i_flush = 1'b0;
      if (flush_now) model_clear_valid();

      if (!hit) begin
         base    = {addr[31:4], 4'b0};
         beat    = 0;
         cyc     = 0;
         pend    = 1'b0;
         aborted = 1'b0;
         while (beat < 4 && cyc < 200 && !aborted) begin
            rdy  = ((cyc % period) == period - 1);
            fl   = (beat == flush_beat) && !pend;
            rs   = (beat == rst_beat);
            if (rs) rdy = 1'b0;
            word = mem_word(base + 32'(beat * 4));
            bus.i_MemReady  = rdy;
            bus.i_DataBlock = word;
            bus.i_flush     = fl;
            rst             = rs;
            #1;
            stall_cyc += int'(bus.o_Stall);
            chk("refill_req",   32'(bus.o_DataReq), 32'd1);
            chk("refill_addr",  bus.o_MemAddr, base + 32'(beat * 4));
            chk("refill_stall", 32'(bus.o_Stall), 32'd1);
            @(posedge clk); #2;
            bus.i_MemReady = 1'b0;
            bus.i_flush    = 1'b0;
            rst            = 1'b0;
            if (fl) pend = 1'b1;
            if (rs) begin
               model_reset();
               aborted = 1'b1;
            end else if (rdy) begin
               m_data[set][vic][beat] = word;
               beat++;
            end
            cyc++;
         end
         if (aborted) begin
            #1;
            chk("reset_req",   32'(bus.o_DataReq), 32'd0);
            chk("reset_maddr", bus.o_MemAddr, 32'd0);
         end else begin
            chk("refill_beats", 32'(beat), 32'd4);
            m_tag[set][vic] = tag;
            if (pend) model_clear_valid();
            else      m_valid[set][vic] = 1'b1;
            m_rr[set] = (m_rr[set] + 1) % 2;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          h;
      int          sc;
      logic [31:0] a;

      bus.i_Addr      = 32'h100;
      bus.i_flush     = 1'b0;
      bus.i_DataBlock = '0;
      bus.i_MemReady  = 1'b0;
      model_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("reset_state_req",   32'(bus.o_DataReq), 32'd0);
      chk("reset_state_maddr", bus.o_MemAddr, 32'd0);
      chk("reset_state_stall", 32'(bus.o_Stall), 32'd1);
      #1;

      // Cold miss, then same-cycle hits within the line.
      fetch(32'h100, 1, -1, 1'b0, -1, h, sc);  chk("cold_miss", 32'(h), 32'd0);
      fetch(32'h100, 1, -1, 1'b0, -1, h, sc);  chk("cold_hit_100", 32'(h), 32'd1);
      fetch(32'h108, 1, -1, 1'b0, -1, h, sc);  chk("cold_hit_108", 32'(h), 32'd1);

      // Idle flush: lookup in the flush cycle still hits, the next one misses.
      fetch(32'h108, 1, -1, 1'b1, -1, h, sc);  chk("flush_cycle_hit", 32'(h), 32'd1);
      fetch(32'h100, 1, -1, 1'b0, -1, h, sc);  chk("post_flush_miss", 32'(h), 32'd0);
      fetch(32'h100, 1, -1, 1'b0, -1, h, sc);  chk("refetch_hit", 32'(h), 32'd1);

      // Replacement within set 0.
      do_reset();
      fetch(32'h000, 1, -1, 1'b0, -1, h, sc);
      fetch(32'h040, 1, -1, 1'b0, -1, h, sc);
      fetch(32'h080, 1, -1, 1'b0, -1, h, sc);  chk("repl_080_miss", 32'(h), 32'd0);
      fetch(32'h040, 1, -1, 1'b0, -1, h, sc);  chk("repl_040_hit", 32'(h), 32'd1);
      fetch(32'h000, 1, -1, 1'b0, -1, h, sc);  chk("repl_000_miss", 32'(h), 32'd0);

      // Wait states: ready every 4th cycle.
      fetch(32'h0D0, 4, -1, 1'b0, -1, h, sc);  chk("wait_stall_cycles", 32'(sc), 32'd17);
      for (int i = 0; i < 4; i++) begin
         fetch(32'h0D0 + 32'(i * 4), 1, -1, 1'b0, -1, h, sc);
         chk("wait_word_hit", 32'(h), 32'd1);
      end

      // Flush during beat 2 of a refill.
      fetch(32'h200, 1, 2, 1'b0, -1, h, sc);
      fetch(32'h200, 1, -1, 1'b0, -1, h, sc);  chk("flush_mid_miss", 32'(h), 32'd0);
      fetch(32'h200, 1, -1, 1'b0, -1, h, sc);  chk("flush_mid_rehit", 32'(h), 32'd1);

      // Reset at beat 1 of a refill.
      fetch(32'h100, 1, -1, 1'b0, -1, h, sc);
      fetch(32'h104, 1, -1, 1'b0, -1, h, sc);  chk("pre_reset_hit", 32'(h), 32'd1);
      fetch(32'h310, 2, -1, 1'b0, 1, h, sc);
      fetch(32'h100, 1, -1, 1'b0, -1, h, sc);  chk("post_reset_miss", 32'(h), 32'd0);

      // Random traffic over a small address pool to exercise hits and evictions.
      for (int i = 0; i < 120; i++) begin
         a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 4)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         fetch(a, int'($urandom_range(1, 3)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
               ($urandom_range(0, 11) == 0), -1, h, sc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i_cache_sa.md
Name: i_cache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the direct-mapped single-word I_CACHE.
- Sits between PC and the instruction-memory port of the core datapath.
- Hits return the instruction combinationally in the same cycle, so single-cycle fetch is kept.
- Misses stall the core and refill a multi-word block as a word-serial burst. Adds N-way associativity, per-set round-robin replacement and whole-cache invalidate (FENCE.I).

Parameters:
- XLEN, 32, data/address width.
- WAYS, 2, associativity; power of 2, 1..8.
- SETS, 16, sets per way; power of 2, >=2.
- BLOCK_WORDS, 4, XLEN-bit words per line; power of 2, 1..16.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  reset; synchronous and active-high (polarity and synchronicity are fixed).
- i_Addr  in  XLEN  fetch address (PC); bits [1:0] ignored.
- i_flush  in  1  invalidate all lines (FENCE.I); single-cycle pulse.
- o_Data  out  XLEN  instruction; valid when o_Stall=0.
- o_Stall  out  1  1 = lookup missed or refill in progress.
- i_DataBlock  in  XLEN  refill word from memory.
- i_MemReady  in  1  refill word valid / request accepted.
- o_DataReq  out  1  refill word request.
- o_MemAddr  out  XLEN  word-aligned refill word address.

Behaviour:
- Address split:
  - OFF = 2 + log2(BLOCK_WORDS); IDX = log2(SETS).
  - offset = i_Addr[OFF-1:2], index = i_Addr[OFF+IDX-1:OFF], tag = i_Addr[XLEN-1:OFF+IDX].
- Lookup (combinational):
  - hit = some way has valid[index] and tag match. At most one way can match.
  - On hit in IDLE: o_Data = data[way][index][offset], o_Stall=0.
- FSM states: IDLE, REFILL.
- IDLE:
  - On miss: o_Stall=1 in the same cycle.
  - Latch block base = {tag, index, OFF'b0} and the victim way.
  - Next state REFILL, beat=0.
- Victim selection:
  - Lowest-numbered invalid way in the set.
  - Otherwise the set's round-robin pointer.
  - The pointer advances (mod WAYS) only when a refill completes into that set.
- REFILL:
  - o_DataReq=1, o_MemAddr = base + 4*beat; o_Stall=1.
  - On i_MemReady: write i_DataBlock into data[victim][index][beat], then beat++.
  - If i_MemReady is low: o_DataReq and o_MemAddr hold stable.
  - On the last beat (beat = BLOCK_WORDS-1 with i_MemReady): write tag, set valid unless a flush is pending, go to IDLE.
  - The following cycle re-looks-up i_Addr and normally hits.
- Refill bookkeeping:
  - The refill uses the latched base; i_Addr changes during REFILL do not affect it.
  - Lookup result is ignored (stall held) while in REFILL.
- Flush:
  - i_flush in IDLE clears every valid bit at the clock edge. A lookup in that same cycle still uses the old valid bits.
  - i_flush in REFILL sets flush_pending. The burst completes (no dropped handshake), all valid bits clear at completion, and the refilled line is not validated.
  - flush_pending clears on completion.
- Reset (any state, including mid-burst):
  - State IDLE, beat=0, all valid=0, RR pointers=0, flush_pending=0.
  - o_DataReq=0 and o_MemAddr=0 from the cycle after the reset edge.
  - After reset with valid=0, o_Stall=1 as soon as i_Addr is looked up.
  - o_Data is don't-care while stalled; it is driven 0 on a miss.
  - Data and tag arrays are not reset.
- Width rules:
  - beat is log2(BLOCK_WORDS) bits, with min 1 bit when BLOCK_WORDS=1.
  - o_MemAddr arithmetic wraps at the XLEN boundary.

Decomposition:
- Shared constants (XLEN, PC_RESET) come from defines.vh.
- Derived localparams OFF, IDX, TAGW and the FSM state encoding live in a shared icache_defs.vh for reuse by the future D-cache.
- One sub-module, ic_way: the tag/valid/data storage of a single way, with read port (index, offset) and write port (index, beat, data, tag write, valid set, clear-all). It is instantiated WAYS times in a generate loop.

Test Plan:
- Config for all scenarios: WAYS=2, SETS=4, BLOCK_WORDS=4.
- Cold miss: reset, i_Addr=0x100 -> o_Stall=1; o_MemAddr sequence 0x100, 0x104, 0x108, 0x10C with memory returning 0xA0..0xA3; next cycle o_Data=0xA0, o_Stall=0; i_Addr=0x108 -> 0xA2 same cycle, no o_DataReq.
- Replacement: fetch 0x000, 0x040, 0x080 (all set 0) -> way0, way1, then 0x080 evicts way0; 0x040 hits, 0x000 misses.
- Wait states: i_MemReady high only every 4th cycle -> o_DataReq=1 and o_MemAddr unchanged between beats; exactly 4 words written; total stall 16+ cycles.
- Flush idle: after the cold fill of 0x100, pulse i_flush -> next fetch of 0x100 stalls and re-refills.
- Flush mid-refill: i_flush during beat 2 of 0x200 -> all 4 beats complete, then the same address misses again.
- Reset mid-refill: i_rst at beat 1 -> o_DataReq=0 the next cycle; fetch of the earlier-cached 0x100 misses.
